// File: rtl/ripple_adder.sv
// WIDTH-bit ripple-carry adder, one full-adder slice per pipeline stage.
// Operand bits are skewed in and sum bits deskewed out so each result leaves together.
module ripple_adder #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic [WIDTH-1:0] S,
   output logic             cout
);

   function automatic logic fa_sum(input logic a, input logic b, input logic c);
      return a ^ b ^ c;
   endfunction

   function automatic logic fa_carry(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Stage k input word: [k-1:0] finished sums, then remaining A bits k..WIDTH-1,
   // then remaining B bits k..WIDTH-1. Each stage consumes bit k of both operands.
   genvar k;
   generate
      for (k = 0; k < WIDTH; k++) begin : g_stage
         localparam int IW = 2 * WIDTH - k;
         localparam int OW = IW - 1;
         localparam int RI = WIDTH - k;

         logic [IW-1:0] word_in_s;
         logic          carry_in_s;
         logic [OW-1:0] word_nxt_s;
         logic          carry_nxt_s;
         logic [OW-1:0] word_r;
         logic          carry_r;

         if (k == 0) begin : g_first
            assign word_in_s  = {B, A};
            assign carry_in_s = cin;
         end else begin : g_next
            assign word_in_s  = g_stage[k-1].word_r;
            assign carry_in_s = g_stage[k-1].carry_r;
         end

         // Full adder for bit k; pass finished sums and not-yet-used operand bits along.
         always_comb begin
            word_nxt_s  = {OW{1'b0}};
            carry_nxt_s = 1'b0;
            for (int i = 0; i < k; i++) begin
               word_nxt_s[i] = word_in_s[i];
            end
            word_nxt_s[k] = fa_sum(word_in_s[k], word_in_s[k+RI], carry_in_s);
            carry_nxt_s   = fa_carry(word_in_s[k], word_in_s[k+RI], carry_in_s);
            for (int j = 0; j < RI - 1; j++) begin
               word_nxt_s[k+1+j]  = word_in_s[k+1+j];
               word_nxt_s[k+RI+j] = word_in_s[k+RI+1+j];
            end
         end

         // Stage register; reset clears it immediately.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               word_r  <= {OW{1'b0}};
               carry_r <= 1'b0;
            end else begin
               word_r  <= word_nxt_s;
               carry_r <= carry_nxt_s;
            end
         end
      end
   endgenerate

   // The last stage word holds exactly the WIDTH sum bits.
   assign S    = g_stage[WIDTH-1].word_r;
   assign cout = g_stage[WIDTH-1].carry_r;

endmodule

// File: tb/tb_ripple_adder.sv
// Scoreboard bench for ripple_adder: stimulus pushes A+B+cin with its due cycle,
// an independent monitor pops and compares when the result is due.
module tb_ripple_adder;
   localparam int W = 4;

   typedef struct {
      int         due;
      logic [W:0] val;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] a, b, s;
   logic         cin, cout;

   exp_t q[$];
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   ripple_adder #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .A   (a),
      .B   (b),
      .cin (cin),
      .S   (s),
      .cout(cout)
   );

   task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got {cout,S}=%h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Apply one operand set for the next rising edge and record its expected result.
   task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
      int   total;
      exp_t e;
      @(negedge clk);
      a   = av;
      b   = bv;
      cin = cv;
      total = int'(av) + int'(bv) + int'(cv);
      e.due = cyc + W;
      e.val = total[W:0];
      q.push_back(e);
   endtask

   task automatic assert_reset(input int ncyc);
      @(negedge clk);
      a   = '1;
      b   = '1;
      cin = 1'b1;
      rst = 1'b1;
      #1;
      check("reset_async", {cout, s}, '0);
      q.delete();
      repeat (ncyc) @(negedge clk);
   endtask

   // Drop reset with zero operands; the flushed pipeline and that sample all read 0.
   task automatic release_reset();
      exp_t e;
      rst = 1'b0;
      a   = '0;
      b   = '0;
      cin = 1'b0;
      for (int i = 0; i < W; i++) begin
         e.due = cyc + 1 + i;
         e.val = '0;
         q.push_back(e);
      end
   endtask

   // Monitor: compare whatever result is due at this edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            check("reset_hold", {cout, s}, '0);
         end else begin
            while (q.size() > 0 && q[0].due < cyc) begin
               e = q.pop_front();
               tests++;
               fails++;
               $display("FAIL missed_result: expected %h due at cycle %0d, now %0d", e.val, e.due, cyc);
            end
            if (q.size() > 0 && q[0].due == cyc) begin
               e = q.pop_front();
               check("result", {cout, s}, e.val);
            end
         end
      end
   end

   initial begin
      int waited;
      rst = 1'b1;
      a   = '1;
      b   = '1;
      cin = 1'b1;
      repeat (5) @(negedge clk);
      release_reset();

      // single add, then zeros
      drive(4'h3, 4'h4, 1'b0);
      repeat (3) drive(4'h0, 4'h0, 1'b0);
      // full carry ripple
      drive(4'hF, 4'h0, 1'b1);
      drive(4'hF, 4'hF, 1'b1);
      // back-to-back stream
      drive(4'h1, 4'h1, 1'b0);
      drive(4'h8, 4'h8, 1'b0);
      drive(4'h7, 4'h8, 1'b1);
      drive(4'h5, 4'hA, 1'b0);
      // random operands
      for (int i = 0; i < 60; i++) begin
         drive(W'($urandom_range(2**W - 1, 0)), W'($urandom_range(2**W - 1, 0)),
               1'($urandom_range(1, 0)));
      end
      // toggle pattern on bit 0 only
      for (int i = 0; i < 100; i++) begin
         drive({3'b000, 1'(i & 1)}, {3'b000, 1'((i >> 1) & 1)}, 1'((i >> 2) & 1));
      end
      // reset with results in flight
      drive(4'h9, 4'h9, 1'b1);
      drive(4'hC, 4'h6, 1'b0);
      drive(4'hE, 4'hB, 1'b1);
      assert_reset(2);
      release_reset();
      drive(4'h6, 4'h7, 1'b1);
      drive(4'hA, 4'h3, 1'b0);
      repeat (W) drive(4'h0, 4'h0, 1'b0);

      waited = 0;
      while (q.size() > 0 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ripple_adder.md
Name: ripple_adder

Overview:
- WIDTH-bit ripple-carry adder with one pipeline stage per bit slice.
- Computes S = A + B + cin with carry-out cout.
- Accepts a new operand set every clock and delivers each result a fixed WIDTH cycles later.
- Datapath arithmetic building block. Its registered, skew-balanced pipeline gives a short critical path of one full-adder per stage.

Parameters:
- WIDTH, 4, operand/sum width in bits; also the pipeline depth. Legal range is 1 or more.

Ports:
- clk  input  1  rising-edge clock for all registers
- rst  input  1  asynchronous, active-high reset; clears every pipeline register
- A  input  WIDTH  addend A, unsigned; narrower drivers are zero-extended
- B  input  WIDTH  addend B, unsigned
- cin  input  1  carry-in
- S  output  WIDTH  registered sum bits
- cout  output  1  registered carry-out of bit WIDTH-1

Behaviour:
- One clock, clk. rst is asynchronous and active-high. No other clock or reset.
- While rst=1, all pipeline registers (operand skew, carry, partial sum, deskew, output) are held at 0, so S=0 and cout=0 immediately.
- Stage k (k=0..WIDTH-1) contains exactly one full adder for bit k:
  - sum_k = a_k ^ b_k ^ c_k
  - c_(k+1) = a_k&b_k | a_k&c_k | b_k&c_k
  - c_0 = cin
- Input skew: bit k of A and B is delayed k register stages so that it meets carry c_k in stage k.
- Output deskew: sum bit k is delayed WIDTH-1-k further stages so that all sum bits and cout of one operand set leave together.
- Latency: operands sampled at rising edge n appear on S/cout right after edge n+WIDTH-1, i.e. WIDTH register stages. For WIDTH=4, results are visible after the 4th edge, counting the sampling edge as the 1st.
- Throughput: one result per clock. No stall or valid handshake; the pipeline always advances.
- Result width: {cout,S} = A + B + cin exactly, modulo 2^(WIDTH+1). Overflow is reported only via cout. No saturation.
- After rst deasserts, the first WIDTH-1 outputs are the flushed zeros (equivalent to 0+0+0), followed by real results.
- Reset mid-operation discards all in-flight results, and outputs go to 0 asynchronously. Operands sampled after release then follow normal latency.
- rst deasserted at or near a clock edge: the first operand set sampled is the one at the first edge where rst is low.
- Outputs depend only on registered state. There is no combinational path from A/B/cin to S/cout.

Test Plan:
- Reset: hold rst=1 for 5 cycles with A=4'hF, B=4'hF, cin=1 -> S=0, cout=0 throughout. Assert rst mid-cycle -> outputs clear without waiting for clk.
- Single add: A=4'h3, B=4'h4, cin=0 sampled at edge n, inputs zeroed afterwards -> S=4'h7, cout=0 after edge n+3; the preceding outputs are 0.
- Full carry ripple: A=4'hF, B=4'h0, cin=1 -> S=4'h0, cout=1 after 4 cycles. Also A=4'hF, B=4'hF, cin=1 -> S=4'hF, cout=1.
- Back-to-back stream: apply (1,1,0), (8,8,0), (7,8,1), (5,A,0) on consecutive edges -> outputs 2/0, 0/1, 0/1, F/0 (S/cout) on 4 consecutive cycles starting 3 edges after the first sample.
- Toggle pattern: period-10 clk, A[0] toggling every 10 ns, B[0] every 20 ns, cin every 40 ns, upper bits 0, rst released at 50 ns -> every output equals the 1-bit A + B + cin sum of the operands from 3 cycles earlier, checked against a software model for 100 cycles.
- Reset mid-stream: assert rst while 3 results are in flight, release after 2 cycles -> no stale results emerge. The first new result appears 4 edges after release.
